hex_display_arbiter: RTL and testbench

Time-shares the board's six seven-segment digits and LED bank among up to `NUM_REQ` user-design requesters. Each requester raises `req` and presents a 24-bit hex value; the arbiter grants one requester at a time in round-robin order for a programmable dwell period, decodes its value onto `hex0`–`hex5`, and shows the active channel on `ledr`. It sits between user logic and the pin_ip peripheral ports, replacing the constant tie-offs on the hex outputs.

---
 rtl/hex_disp_pkg.sv | 19 +
 rtl/hex7seg.sv | 11 +
 rtl/hex_display_arbiter.sv | 168 ++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display arbiter.
// Optional build macro: HEX_DP_CHANNEL_EN (lights the dp of the granted channel's digit).
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SHOW   = 2'd2
  } arb_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g in bits 0..6, dp (bit 7) off; index is the nibble value.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder (segments a..g only).
module hex7seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble][6:0];

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin time-sharing of six seven-segment digits and the LED bank among NUM_REQ requesters.
// Optional build macro: HEX_DP_CHANNEL_EN marks the granted channel with the dp of hex<index>.
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                    max10_clk1_50,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*24-1:0]   data,
  input  logic                    advance,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic [7:0]              hex0,
  output logic [7:0]              hex1,
  output logic [7:0]              hex2,
  output logic [7:0]              hex3,
  output logic [7:0]              hex4,
  output logic [7:0]              hex5,
  output logic [9:0]              ledr
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_INIT  = IDXW'(NUM_REQ - 1);

  arb_state_t          state_reg, state_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [IDXW-1:0]     last_reg, last_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                busy_reg;
  logic [47:0]         hex_reg, hex_next;

  logic [IDXW-1:0]     pick;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                owner_req;
  logic                others_pending;
  logic                end_event;
  logic [23:0]         owner_data;
  logic [41:0]         seg_bus;
  logic [5:0]          dp_off;

  // First requester with req high, scanning circularly from l+1 (l itself is checked last).
  function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDXW-1:0]    l);
    logic            found;
    logic [IDXW-1:0] cand;
    int              idx;
    rr_pick = l;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(l) + i) % NUM_REQ;
      cand = IDXW'(idx);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick           = rr_pick(req, last_reg);
  assign owner_mask     = NUM_REQ'(1) << last_reg;
  assign owner_req      = |(req & owner_mask);
  assign others_pending = |(req & ~owner_mask);
  assign end_event      = (count_reg == DWELL_LAST) || advance || !owner_req;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        grant_next = '0;
        count_next = '0;
        if (|req) state_next = SELECT;
      end
      SELECT: begin
        count_next = '0;
        if (|req) begin
          last_next  = pick;
          grant_next = NUM_REQ'(1) << pick;
          state_next = SHOW;
        end else begin
          grant_next = '0;
          state_next = IDLE;
        end
      end
      SHOW: begin
        count_next = count_reg + 1'b1;
        if (end_event) begin
          if (others_pending) begin
            grant_next = '0;
            state_next = SELECT;
          end else if (owner_req) begin
            // Sole requester keeps the display; only the dwell restarts.
            count_next = '0;
          end else begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        grant_next = '0;
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_reg == IDXW'(i)) owner_data = data[24*i +: 24];
    end
  end

  // Digits are live in SHOW, blank in IDLE, and hold across the SELECT gap.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : gen_digit
      hex7seg u_dec (
        .nibble (owner_data[4*gi +: 4]),
        .seg    (seg_bus[7*gi +: 7])
      );
`ifdef HEX_DP_CHANNEL_EN
      assign dp_off[gi] = (int'(last_reg) != gi);
`else
      assign dp_off[gi] = 1'b1;
`endif
      assign hex_next[8*gi +: 8] = (state_reg == SHOW) ? {dp_off[gi], seg_bus[7*gi +: 7]} :
                                   (state_reg == IDLE) ? SEG_BLANK :
                                                         hex_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge max10_clk1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= LAST_INIT;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      hex_reg   <= {6{SEG_BLANK}};
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      count_reg <= count_next;
      busy_reg  <= (state_reg != IDLE);
      hex_reg   <= hex_next;
    end
  end

  assign grant = grant_reg;
  assign busy  = busy_reg;
  assign hex0  = hex_reg[7:0];
  assign hex1  = hex_reg[15:8];
  assign hex2  = hex_reg[23:16];
  assign hex3  = hex_reg[31:24];
  assign hex4  = hex_reg[39:32];
  assign hex5  = hex_reg[47:40];
  assign ledr  = {busy_reg, {(9-NUM_REQ){1'b0}}, grant_reg};

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: a reference model predicts every output change
// with its cycle stamp; a monitor compares each observed change against the queue.
module tb_hex_display_arbiter;

  localparam int N = 4;
  localparam int D = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*24-1:0] data = '0;
  logic            advance = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;
  logic [7:0]      hex0, hex1, hex2, hex3, hex4, hex5;
  logic [9:0]      ledr;

  always #10 clk = ~clk;

  hex_display_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(D)) dut (
    .max10_clk1_50 (clk),
    .reset_n       (reset_n),
    .req           (req),
    .data          (data),
    .advance       (advance),
    .grant         (grant),
    .busy          (busy),
    .hex0          (hex0),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .hex4          (hex4),
    .hex5          (hex5),
    .ledr          (ledr)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          stamp;
    logic [63:0] vec;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [63:0] RESET_VEC = {1'b0, 4'b0, 1'b0, 10'b0, {6{8'hFF}}};

  // Reference model: phase 0 = idle, 1 = choosing, 2 = showing.
  int          m_phase, m_owner, m_last, m_age;
  bit          m_busy;
  logic [7:0]  m_disp [6];
  logic [63:0] m_prev_vec;
  int          drv_cyc = 0;
  int          mon_cyc = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) mon_cyc <= mon_cyc + 1;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [63:0] dut_vec();
    return {1'b0, grant, busy, ledr, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  function automatic logic [63:0] model_vec();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {1'b0, g, m_busy, m_busy, 5'b0, g,
            m_disp[5], m_disp[4], m_disp[3], m_disp[2], m_disp[1], m_disp[0]};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = -1;
    m_last  = N - 1;
    m_age   = 0;
    m_busy  = 1'b0;
    for (int k = 0; k < 6; k++) m_disp[k] = 8'hFF;
  endtask

  task automatic model_step();
    int was;
    bit held, rivals, done;
    was = m_phase;
    case (m_phase)
      0: begin
        for (int k = 0; k < 6; k++) m_disp[k] = 8'hFF;
        if (|req) m_phase = 1;
      end
      1: begin
        if (|req) begin
          for (int s = 1; s <= N; s++) begin
            if (req[(m_last + s) % N]) begin
              m_owner = (m_last + s) % N;
              break;
            end
          end
          m_last  = m_owner;
          m_age   = 0;
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end
      default: begin
        for (int k = 0; k < 6; k++) begin
          m_disp[k] = seg_of(data[24*m_owner + 4*k +: 4]);
`ifdef HEX_DP_CHANNEL_EN
          if (k == m_owner) m_disp[k][7] = 1'b0;
`endif
        end
        held = req[m_owner];
        rivals = 1'b0;
        for (int j = 0; j < N; j++) if (j != m_owner && req[j]) rivals = 1'b1;
        done = (m_age == D - 1) || advance || !held;
        m_age++;
        if (done) begin
          if (rivals) begin
            m_owner = -1;
            m_phase = 1;
          end else if (held) begin
            m_age = 0;
          end else begin
            m_owner = -1;
            m_phase = 0;
          end
        end
      end
    endcase
    m_busy = (was != 0);
  endtask

  task automatic push_if_changed(input int stamp);
    logic [63:0] v;
    v = model_vec();
    if (v !== m_prev_vec) begin
      exp_q.push_back('{stamp, v});
      m_prev_vec = v;
    end
  endtask

  // One clock of stimulus; rst asserts reset_n mid-cycle, the next non-reset call releases it.
  task automatic cycle(input logic [N-1:0] r, input logic [N*24-1:0] d, input logic a, input bit rst);
    @(negedge clk);
    req = r;
    data = d;
    advance = a;
    if (rst) begin
      #2 reset_n = 1'b0;
      model_reset();
      push_if_changed(drv_cyc + 1);
      #1;
      vectors++;
      if (dut_vec() !== RESET_VEC) begin
        miscompares++;
        $display("FAIL async_reset cyc=%0d got=%h want=%h", drv_cyc, dut_vec(), RESET_VEC);
      end
    end else if (!reset_n) begin
      #2 reset_n = 1'b1;
    end
    @(posedge clk);
    drv_cyc++;
    if (reset_n) model_step();
    push_if_changed(drv_cyc);
  endtask

  // Monitor: every change of the DUT outputs must match the next predicted change and its cycle.
  initial begin
    logic [63:0] last_dut, v;
    exp_t e;
    wait (mon_en);
    last_dut = dut_vec();
    forever begin
      @(negedge clk);
      v = dut_vec();
      if (v !== last_dut) begin
        last_dut = v;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d got=%h want=no change", mon_cyc, v);
        end else begin
          e = exp_q.pop_front();
          if (e.stamp != mon_cyc || e.vec !== v) begin
            miscompares++;
            $display("FAIL output_change cyc=%0d got=%h want=%h at cyc=%0d",
                     mon_cyc, v, e.vec, e.stamp);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0]    r;
    logic [N*24-1:0] d;
    exp_t            e;

    model_reset();
    m_prev_vec = model_vec();
    repeat (3) begin
      @(posedge clk);
      drv_cyc++;
    end
    #5;
    vectors++;
    if (dut_vec() !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", dut_vec(), RESET_VEC);
    end
    mon_en = 1'b1;

    // Two requesters alternating with full dwell periods.
    d = {$urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 60; i++) cycle(4'b0101, d, 1'b0, 1'b0);

    // Sole requester 2 held indefinitely, then live data change, then release.
    d[71:48] = 24'h0123AF;
    for (int i = 0; i < 30; i++) cycle(4'b0100, d, 1'b0, 1'b0);
    d[71:48] = 24'hFEDCB9;
    for (int i = 0; i < 5; i++) cycle(4'b0100, d, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(4'b0000, d, 1'b0, 1'b0);

    // Advance in IDLE, then early rotation by advance.
    cycle(4'b0000, d, 1'b1, 1'b0);
    cycle(4'b0000, d, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b0011, d, 1'b0, 1'b0);
    cycle(4'b0011, d, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'b0011, d, 1'b0, 1'b0);

    // Reset during SHOW, then restart with two pending requesters.
    for (int i = 0; i < 5; i++) cycle(4'b1100, d, 1'b0, 1'b0);
    cycle(4'b1100, d, 1'b0, 1'b1);
    cycle(4'b1010, d, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(4'b1010, d, 1'b0, 1'b0);

    // Randomised traffic.
    r = 4'b0000;
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 7) == 0) d = {$urandom(), $urandom(), $urandom()};
      cycle(r, d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 599) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(4'b0000, d, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_change want=%h at cyc=%0d", e.vec, e.stamp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
